// File: rtl/ddr3_test_pkg.sv
// Shared encodings and the test-pattern generator for the DDR3 read/write self-test.
package ddr3_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_DONE  = 2'b11
    } test_state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Widest data bus the pattern helper supports; callers truncate to their width.
    localparam int PAT_MAX_W = 1024;

    function automatic logic [PAT_MAX_W-1:0] pat(input logic [15:0] idx,
                                                 input logic [15:0] pass,
                                                 input int          width);
        logic [PAT_MAX_W-1:0] r;
        logic [15:0]          lane;
        r    = '0;
        lane = idx + pass;
        for (int k = 0; k < PAT_MAX_W / 16; k++) begin
            if (k < width / 16) r[k*16 +: 16] = lane;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr3_rd_checker.sv
// Read-return checker: tracks in-order beats, compares them with the expected
// pattern, watches for stalled returns and holds the sticky error.
module ddr3_rd_checker
    import ddr3_test_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int BURST_NUM  = 64,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  active,
    input  logic [15:0]           pass_cnt,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  rd_done,
    output logic                  rd_err
);

    localparam int               IDX_W    = 17;
    localparam int               TMO_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(BURST_NUM);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    logic [IDX_W-1:0]      rd_dat_idx_q, rd_dat_idx_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  err_q, err_d;
    logic                  waiting, mismatch, tmo_fire;
    logic [DATA_WIDTH-1:0] exp_data;

    always_comb begin
        waiting      = active && (rd_dat_idx_q != IDX_END);
        exp_data     = DATA_WIDTH'(pat(rd_dat_idx_q[15:0], pass_cnt, DATA_WIDTH));
        mismatch     = waiting && rd_valid && (rd_data != exp_data);
        // The increment that would land on RD_TIMEOUT is the timeout event itself.
        tmo_fire     = waiting && !rd_valid && (tmo_cnt_q == TMO_LAST);
        rd_dat_idx_d = rd_dat_idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q | mismatch | tmo_fire;
        if (!active) begin
            rd_dat_idx_d = '0;
            tmo_cnt_d    = '0;
        end else if (waiting && rd_valid) begin
            rd_dat_idx_d = rd_dat_idx_q + 1'b1;
            tmo_cnt_d    = '0;
        end else if (waiting) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        rd_done = active && ((rd_dat_idx_q == IDX_END) || tmo_fire);
        rd_err  = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_idx_q <= '0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            rd_dat_idx_q <= rd_dat_idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: rtl/ddr3_rw_test_ctrl.sv
// DDR3 self-test sequencer: after calibration, writes a pattern window, reads it
// back through the checker, counts passes and repeats forever.
module ddr3_rw_test_ctrl
    import ddr3_test_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int START_ADDR = 0,
    parameter int ADDR_STEP  = 8,
    parameter int BURST_NUM  = 64,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic                  error_flag,
    output logic [1:0]            test_state,
    output logic [15:0]           pass_cnt
);

    localparam int                    IDX_W     = 17;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BURST_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(ADDR_STEP);

    test_state_e           state_q, state_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_cmd_idx_q, rd_cmd_idx_d;
    logic                  app_en_q, app_en_d;
    logic [2:0]            app_cmd_q, app_cmd_d;
    logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic                  app_wdf_wren_q, app_wdf_wren_d;
    logic [DATA_WIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
    logic [15:0]           pass_cnt_q, pass_cnt_d;
    logic                  wr_acc, rd_acc, rd_active, rd_done, rd_err;

    assign rd_active = (state_q == ST_READ);

    ddr3_rd_checker #(
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_NUM (BURST_NUM),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) u_rd_checker (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .active  (rd_active),
        .pass_cnt(pass_cnt_q),
        .rd_data (app_rd_data),
        .rd_valid(app_rd_data_valid),
        .rd_done (rd_done),
        .rd_err  (rd_err)
    );

    always_comb begin
        wr_acc = (state_q == ST_WRITE) && app_en_q && app_wdf_wren_q && app_rdy && app_wdf_rdy;
        rd_acc = (state_q == ST_READ) && app_en_q && app_rdy;

        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_cmd_idx_d   = rd_cmd_idx_q;
        app_en_d       = app_en_q;
        app_cmd_d      = app_cmd_q;
        app_addr_d     = app_addr_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_wdf_data_d = app_wdf_data_q;
        pass_cnt_d     = pass_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (init_calib_complete) begin
                    state_d        = ST_WRITE;
                    wr_idx_d       = '0;
                    app_en_d       = 1'b1;
                    app_wdf_wren_d = 1'b1;
                    app_cmd_d      = CMD_WR;
                    app_addr_d     = ADDR_BASE;
                    app_wdf_data_d = DATA_WIDTH'(pat(16'd0, pass_cnt_q, DATA_WIDTH));
                end
            end
            ST_WRITE: begin
                if (!init_calib_complete) begin
                    state_d        = ST_IDLE;
                    app_en_d       = 1'b0;
                    app_wdf_wren_d = 1'b0;
                    wr_idx_d       = '0;
                    rd_cmd_idx_d   = '0;
                end else if (wr_acc) begin
                    if (wr_idx_q == IDX_LAST) begin
                        // Read commands start on the very next cycle.
                        state_d        = ST_READ;
                        wr_idx_d       = '0;
                        rd_cmd_idx_d   = '0;
                        app_wdf_wren_d = 1'b0;
                        app_en_d       = 1'b1;
                        app_cmd_d      = CMD_RD;
                        app_addr_d     = ADDR_BASE;
                    end else begin
                        wr_idx_d       = wr_idx_q + 1'b1;
                        app_addr_d     = app_addr_q + ADDR_INC;
                        app_wdf_data_d = DATA_WIDTH'(pat(wr_idx_q[15:0] + 16'd1, pass_cnt_q,
                                                         DATA_WIDTH));
                    end
                end
            end
            ST_READ: begin
                if (!init_calib_complete) begin
                    state_d        = ST_IDLE;
                    app_en_d       = 1'b0;
                    app_wdf_wren_d = 1'b0;
                    wr_idx_d       = '0;
                    rd_cmd_idx_d   = '0;
                end else begin
                    if (rd_acc) begin
                        rd_cmd_idx_d = rd_cmd_idx_q + 1'b1;
                        app_addr_d   = app_addr_q + ADDR_INC;
                        if (rd_cmd_idx_q == IDX_LAST) app_en_d = 1'b0;
                    end
                    // A timeout ends the phase even with commands outstanding.
                    if (rd_done) begin
                        state_d      = ST_DONE;
                        app_en_d     = 1'b0;
                        rd_cmd_idx_d = '0;
                    end
                end
            end
            ST_DONE: begin
                pass_cnt_d = pass_cnt_q + 16'd1;
                if (init_calib_complete) begin
                    state_d        = ST_WRITE;
                    wr_idx_d       = '0;
                    app_en_d       = 1'b1;
                    app_wdf_wren_d = 1'b1;
                    app_cmd_d      = CMD_WR;
                    app_addr_d     = ADDR_BASE;
                    app_wdf_data_d = DATA_WIDTH'(pat(16'd0, pass_cnt_q + 16'd1, DATA_WIDTH));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_idx_q       <= '0;
            rd_cmd_idx_q   <= '0;
            app_en_q       <= 1'b0;
            app_cmd_q      <= '0;
            app_addr_q     <= '0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
            pass_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_cmd_idx_q   <= rd_cmd_idx_d;
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_data_q <= app_wdf_data_d;
            pass_cnt_q     <= pass_cnt_d;
        end
    end

    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign app_wdf_data = app_wdf_data_q;
    assign error_flag   = rd_err;
    assign test_state   = state_q;
    assign pass_cnt     = pass_cnt_q;

endmodule
